// File: rtl/serial_add.sv
// Bit-serial ripple adder: one full-add stage plus a carry flop, LSB first, WIDTH cycles per operation.
// Define SERIAL_ADD_SUB_EN to add the sub port and a full-subtract stage with a borrow flop.
module serial_add #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             accept;
  logic             bit_a, bit_b;
  logic             s_bit;
  logic             c_add;
  logic             c_next;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub_q, sub_d;
  logic             c_sub;
`endif

  // Single-bit stage: the sum/difference bit is the same XOR for both modes.
  always_comb begin
    bit_a = a_sh_q[0];
    bit_b = b_sh_q[0];
    s_bit = bit_a ^ bit_b ^ carry_q;
    c_add = (bit_a & bit_b) | (bit_a & carry_q) | (bit_b & carry_q);
`ifdef SERIAL_ADD_SUB_EN
    c_sub  = (~bit_a & carry_q) | (~bit_a & bit_b) | (bit_b & carry_q);
    c_next = sub_q ? c_sub : c_add;
`else
    c_next = c_add;
`endif
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case leaves one unassigned (no latches).
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    accept  = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub_d   = sub_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        res_d   = {s_bit, res_q[WIDTH-1:1]};
        carry_d = c_next;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          sum_d   = res_d;
          cout_d  = c_next;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        // Back-to-back: a start seen during the done pulse is accepted immediately.
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      a_sh_d  = a;
      b_sh_d  = b;
      carry_d = cin;
      res_d   = '0;
      cnt_d   = '0;
`ifdef SERIAL_ADD_SUB_EN
      sub_d   = sub;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values computed above.
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add.sv
// Self-checking bench for serial_add: WIDTH=8 directed/random tests plus an exhaustive WIDTH=4 sweep.
// Subtract tests are compiled in when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, cin8, sub8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       start4, cin4, sub4;
  logic [3:0] a4, b4;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int checks = 0;
  int errors = 0;
  bit overlap = 1'b0;

  always #5 clk = ~clk;

  serial_add #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub4),
`endif
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  always @(negedge clk) if ((busy8 === 1'b1 && done8 === 1'b1) || (busy4 === 1'b1 && done4 === 1'b1)) overlap = 1'b1;

  // Reference: plain integer arithmetic, result packed as {cout, sum}.
  function automatic logic [32:0] model(input longint unsigned a, input longint unsigned b,
                                        input bit c, input bit s, input int w);
    longint unsigned m = 64'd1 << w;
    longint unsigned r;
    logic            co;
    if (!s) begin
      r  = a + b + longint'(c);
      co = (r >= m);
      r  = r % m;
    end else begin
      co = (a < b + longint'(c));
      r  = (a + m - b - longint'(c)) % m;
    end
    return {co, r[31:0]};
  endfunction

  task automatic scramble8();
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
  endtask

  // Drives one WIDTH=8 operation; lat = negedges from the start edge until done (-1 on timeout).
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s,
                        output logic [7:0] rs, output logic rc, output int lat, output int bcnt);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; sub8 = s; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    scramble8();
    lat = 0; bcnt = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      if (busy8 === 1'b1) bcnt++;
      @(negedge clk);
      scramble8();
      lat++;
    end
    if (lat >= 40) lat = -1;
    rs = sum8; rc = cout8;
  endtask

  task automatic do_op4(input logic [3:0] a, input logic [3:0] b, input logic c,
                        output logic [3:0] rs, output logic rc, output int lat);
    @(negedge clk);
    a4 = a; b4 = b; cin4 = c; sub4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom);
    lat = 0;
    while (done4 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) lat = -1;
    rs = sum4; rc = cout4;
  endtask

  task automatic check_op8(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic c, input logic s);
    logic [7:0]  rs;
    logic        rc;
    int          lat, bcnt;
    logic [32:0] exp;
    exp = model(a, b, c, s, 8);
    do_op8(a, b, c, s, rs, rc, lat, bcnt);
    checks++;
    if (rs !== exp[7:0] || rc !== exp[32] || lat != 8) begin
      errors++;
      $display("FAIL %s a=%h b=%h cin=%0d sub=%0d: got sum=%h cout=%0d lat=%0d, want sum=%h cout=%0d lat=8",
               name, a, b, c, s, rs, rc, lat, exp[7:0], exp[32]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start8 = 1'b0; start4 = 1'b0;
    scramble8(); a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0 ||
        busy4 !== 1'b0 || done4 !== 1'b0 || sum4 !== 4'h0 || cout4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%0d done=%0d sum=%h cout=%0d, want all 0", busy8, done8, sum8, cout8);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] rs;
    logic       rc;
    int         lat, bcnt;
    do_op8(8'h5A, 8'h3C, 1'b0, 1'b0, rs, rc, lat, bcnt);
    checks++;
    if (lat != 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", lat); end
    checks++;
    if (bcnt != 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 8", bcnt); end
    checks++;
    if (rs !== 8'h96 || rc !== 1'b0) begin
      errors++; $display("FAIL basic_result: got sum=%h cout=%0d want sum=96 cout=0", rs, rc);
    end
    @(negedge clk);
    checks++;
    if (done8 !== 1'b0) begin errors++; $display("FAIL done_one_cycle: done=%0d want 0", done8); end
  endtask

  task automatic test_corners();
    check_op8("ff_plus_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    check_op8("ff_plus_ff_c1", 8'hFF, 8'hFF, 1'b1, 1'b0);
    check_op8("zero_plus_zero", 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++)
      check_op8("random_add", 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic test_sweep4();
    logic [3:0]  rs;
    logic        rc;
    int          lat;
    logic [32:0] exp;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++) begin
          exp = model(longint'(x), longint'(y), c[0], 1'b0, 4);
          do_op4(4'(x), 4'(y), c[0], rs, rc, lat);
          checks++;
          if (rs !== exp[3:0] || rc !== exp[32] || lat != 4) begin
            errors++;
            $display("FAIL sweep4 a=%0d b=%0d cin=%0d: got sum=%h cout=%0d lat=%0d want sum=%h cout=%0d lat=4",
                     x, y, c, rs, rc, lat, exp[3:0], exp[32]);
          end
        end
  endtask

  task automatic test_ignore_start();
    int k = 0;
    @(negedge clk);
    a8 = 8'h21; b8 = 8'h13; cin8 = 1'b1; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    while (done8 !== 1'b1 && k < 40) begin
      if (k == 3) begin
        a8 = 8'hC3; b8 = 8'h77; cin8 = 1'b0; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start8 = 1'b0;
    checks++;
    if (k != 8 || sum8 !== 8'h35 || cout8 !== 1'b0) begin
      errors++; $display("FAIL ignore_start: got sum=%h cout=%0d lat=%0d want sum=35 cout=0 lat=8", sum8, cout8, k);
    end
    @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++; $display("FAIL ignore_start_idle: busy=%0d done=%0d want 0 0", busy8, done8);
    end
  endtask

  task automatic test_back_to_back();
    int          k = 0;
    int          t1 = -1;
    logic [32:0] e1, e2;
    e1 = model(64'h9C, 64'h85, 1'b0, 1'b0, 8);
    e2 = model(64'h3E, 64'h41, 1'b1, 1'b0, 8);
    @(negedge clk);
    a8 = 8'h9C; b8 = 8'h85; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    while (done8 !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    t1 = k;
    checks++;
    if (sum8 !== e1[7:0] || cout8 !== e1[32] || t1 != 8) begin
      errors++; $display("FAIL b2b_first: got sum=%h cout=%0d lat=%0d want sum=%h cout=%0d lat=8",
                         sum8, cout8, t1, e1[7:0], e1[32]);
    end
    a8 = 8'h3E; b8 = 8'h41; cin8 = 1'b1;
    @(negedge clk);
    k++;
    start8 = 1'b0;
    scramble8();
    checks++;
    if (busy8 !== 1'b1) begin errors++; $display("FAIL b2b_restart: busy=%0d want 1", busy8); end
    while (done8 !== 1'b1 && k < 80) begin @(negedge clk); k++; end
    checks++;
    if (k - t1 != 9) begin errors++; $display("FAIL b2b_period: got %0d want 9", k - t1); end
    checks++;
    if (sum8 !== e2[7:0] || cout8 !== e2[32]) begin
      errors++; $display("FAIL b2b_second: got sum=%h cout=%0d want sum=%h cout=%0d", sum8, cout8, e2[7:0], e2[32]);
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    int pulses = 0;
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    while (k < 4) begin @(negedge clk); k++; end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (busy8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
      errors++; $display("FAIL reset_mid: busy=%0d sum=%h cout=%0d want 0 00 0", busy8, sum8, cout8);
    end
    repeat (15) begin
      if (done8 === 1'b1 || busy8 === 1'b1) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL reset_mid_no_done: activity=%0d want 0", pulses); end
    check_op8("after_reset", 8'hA7, 8'h6B, 1'b1, 1'b0);
  endtask

  task automatic test_hold_stable();
    int         changes = 0;
    logic [7:0] held_s;
    logic       held_c;
    check_op8("before_hold", 8'h81, 8'h80, 1'b1, 1'b0);
    held_s = sum8; held_c = cout8;
    repeat (12) begin
      @(negedge clk);
      scramble8();
      if (sum8 !== held_s || cout8 !== held_c) changes++;
    end
    checks++;
    if (changes != 0 || held_s !== 8'h02 || held_c !== 1'b1) begin
      errors++; $display("FAIL sum_stable: changes=%0d sum=%h cout=%0d want 0 changes sum=02 cout=1",
                         changes, held_s, held_c);
    end
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    check_op8("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1);
    check_op8("sub_00_01", 8'h00, 8'h01, 1'b0, 1'b1);
    check_op8("sub_05_05_b1", 8'h05, 8'h05, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++)
      check_op8("random_mixed", 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_sweep4();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_hold_stable();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    checks++;
    if (overlap) begin errors++; $display("FAIL busy_done_overlap: busy and done were high together"); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
